// File: rtl/renode_ahb_pkg.sv
// AHB-Lite encodings shared by the host-bridged subordinate and its bench.
package renode_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  // Sizes above a doubleword are rejected elsewhere, so the low three address bits suffice.
  function automatic logic addr_aligned(input logic [2:0] addr_lo, input logic [2:0] size);
    logic [2:0] mask;
    mask = (3'd1 << size) - 3'd1;
    return (addr_lo & mask) == 3'd0;
  endfunction

endpackage

// File: rtl/renode_ahb_subordinate.sv
// AHB-Lite subordinate forwarding each transfer to a host over req_valid/req_ready plus a pulsed response.
// Data phase >= 3 cycles (reads) / 4 (writes); waits while the host stalls; two-cycle ERROR on fault or timeout.
module renode_ahb_subordinate
  import renode_ahb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  output logic [2:0]            req_size,
  input  logic                  resp_valid,
  input  logic [DATA_WIDTH-1:0] resp_rdata,
  input  logic                  resp_error
);

  typedef enum logic [2:0] {IDLE, WDATA, REQ, WAIT_RESP, DONE, ERR1, ERR2} state_e;

  localparam logic [2:0]       MAX_SIZE = (DATA_WIDTH == 64) ? HSIZE_DWORD : HSIZE_WORD;
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;
  logic                  req_valid_q, req_valid_d;
  logic                  accept;
  logic                  xfer_legal;
  logic                  timeout_hit;
  logic                  unused_ok;

  // NONSEQ and SEQ both carry HTRANS[1]; new address phases are only taken while the bus sees us ready.
  assign accept      = HSEL && HREADY && HTRANS[1] &&
                       (state_q == IDLE || state_q == DONE || state_q == ERR2);
  assign xfer_legal  = (HSIZE <= MAX_SIZE) && addr_aligned(HADDR[2:0], HSIZE);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  assign unused_ok   = ^{HBURST, HTRANS[0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, DONE, ERR2: begin
        state_d = IDLE;
        if (accept) begin
          addr_d  = HADDR;
          write_d = HWRITE;
          size_d  = HSIZE;
          if (!xfer_legal)  state_d = ERR1;
          else if (HWRITE)  state_d = WDATA;
          else              state_d = REQ;
        end
      end
      WDATA: begin
        wdata_d = HWDATA;
        state_d = REQ;
      end
      // A request still pending at the deadline is withdrawn rather than handed over late.
      REQ: begin
        if (timeout_hit)    state_d = ERR1;
        else if (req_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (resp_valid) begin
          if (resp_error) state_d = ERR1;
          else begin
            state_d = DONE;
            rdata_d = write_q ? '0 : resp_rdata;
          end
        end else if (timeout_hit) begin
          state_d = ERR1;
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase

    if (state_d == ERR1) rdata_d = '0;

    if (state_d == REQ && state_q != REQ)            cnt_d = '0;
    else if (state_q == REQ || state_q == WAIT_RESP) cnt_d = cnt_q + CNT_W'(1);

    hreadyout_d = (state_d == IDLE) || (state_d == DONE) || (state_d == ERR2);
    hresp_d     = (state_d == ERR1 || state_d == ERR2) ? HRESP_ERROR : HRESP_OKAY;
    req_valid_d = (state_d == REQ);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = rdata_q;
  assign req_valid = req_valid_q;
  assign req_write = write_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;
  assign req_size  = size_q;

endmodule

// File: tb/tb_renode_ahb_subordinate.sv
// Directed bench: per-cycle vector table for reads/errors/back-to-back, hand sequences for write, timeout and reset.
module tb_renode_ahb_subordinate;
  import renode_ahb_pkg::*;

  logic        HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic        req_valid, req_ready, req_write, resp_valid, resp_error;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_size;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    logic        sel;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        rerr;
    logic        e_hrdy;
    logic        e_hresp;
    logic [31:0] e_hrdata;
    logic        e_reqv;
    logic [31:0] e_raddr;
  } vec_t;

  vec_t vecs[$];

  assign HREADY = HREADYOUT;

  renode_ahb_subordinate #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_error(resp_error)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic rdy, input logic rv,
                       input logic [31:0] rd, input logic rerr);
    HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a;
    req_ready = rdy; resp_valid = rv; resp_rdata = rd; resp_error = rerr;
  endtask

  task automatic add(input string n, input logic sel, input logic [1:0] tr, input logic [2:0] sz,
                     input logic [31:0] a, input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic rerr, input logic eh, input logic er, input logic [31:0] ed,
                     input logic ev, input logic [31:0] ea);
    vec_t v;
    v.name = n; v.sel = sel; v.trans = tr; v.size = sz; v.addr = a;
    v.rdy = rdy; v.rv = rv; v.rdata = rd; v.rerr = rerr;
    v.e_hrdy = eh; v.e_hresp = er; v.e_hrdata = ed; v.e_reqv = ev; v.e_raddr = ea;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, ".hreadyout"}, HREADYOUT, 1'b1);
    chk1({tag, ".hresp"}, HRESP, 1'b0);
    chk({tag, ".hrdata"}, HRDATA, 32'h0);
    chk1({tag, ".req_valid"}, req_valid, 1'b0);
    chk({tag, ".req_addr"}, req_addr, 32'h0);
  endtask

  initial begin
    vec_t v;
    int   low;
    logic seen;

    HRESETn = 1'b0; HBURST = 3'd0; HWDATA = 32'h0;
    drive(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    chk_reset_outputs("reset");
    chk({"reset", ".req_wdata"}, req_wdata, 32'h0);
    chk({"reset", ".req_size"}, {29'd0, req_size}, 32'h0);
    chk1("reset.req_write", req_write, 1'b0);
    HRESETn = 1'b1;

    //  name        sel   trans          size  addr          rdy   rv    rdata         rerr  hrdy  hresp hrdata        reqv  req_addr
    add("idle",     1'b1, HTRANS_IDLE,   3'd2, 32'h0000_0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0);
    add("busy",     1'b1, HTRANS_BUSY,   3'd2, 32'h0000_1000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0);
    add("unsel",    1'b0, HTRANS_NONSEQ, 3'd2, 32'h0000_1000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0);
    add("rd_addr",  1'b1, HTRANS_NONSEQ, 3'd2, 32'h0000_1000, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1000);
    add("rd_req",   1'b0, HTRANS_IDLE,   3'd2, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0);
    add("rd_wait",  1'b0, HTRANS_IDLE,   3'd2, 32'h0,         1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0);
    add("rd_hold",  1'b0, HTRANS_IDLE,   3'd2, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0);
    add("mis_addr", 1'b1, HTRANS_NONSEQ, 3'd2, 32'h0000_1002, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0);
    add("mis_err1", 1'b0, HTRANS_IDLE,   3'd2, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0);
    add("hw_b2b",   1'b1, HTRANS_NONSEQ, 3'd1, 32'h0000_1002, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1002);
    add("hw_req",   1'b0, HTRANS_IDLE,   3'd1, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0);
    add("hw_wait",  1'b0, HTRANS_IDLE,   3'd1, 32'h0,         1'b0, 1'b1, 32'h0000BEEF, 1'b0, 1'b1, 1'b0, 32'h0000BEEF, 1'b0, 32'h0);
    add("hw_hold",  1'b0, HTRANS_IDLE,   3'd1, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0000BEEF, 1'b0, 32'h0);
    add("big_addr", 1'b1, HTRANS_NONSEQ, 3'd3, 32'h0000_0000, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0);
    add("big_err1", 1'b0, HTRANS_IDLE,   3'd2, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0);
    add("big_err2", 1'b0, HTRANS_IDLE,   3'd2, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0);
    add("b2b_a0",   1'b1, HTRANS_NONSEQ, 3'd2, 32'h0000_0000, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0);
    add("b2b_r0",   1'b1, HTRANS_NONSEQ, 3'd2, 32'h0000_0004, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0);
    add("b2b_w0",   1'b1, HTRANS_NONSEQ, 3'd2, 32'h0000_0004, 1'b1, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 32'h11111111, 1'b0, 32'h0);
    add("b2b_a4",   1'b1, HTRANS_NONSEQ, 3'd2, 32'h0000_0004, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h11111111, 1'b1, 32'h4);
    add("b2b_r4",   1'b0, HTRANS_IDLE,   3'd2, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h11111111, 1'b0, 32'h0);
    add("b2b_w4",   1'b0, HTRANS_IDLE,   3'd2, 32'h0,         1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1, 1'b0, 32'h22222222, 1'b0, 32'h0);
    add("stray_rv", 1'b0, HTRANS_IDLE,   3'd2, 32'h0,         1'b0, 1'b1, 32'h33333333, 1'b0, 1'b1, 1'b0, 32'h22222222, 1'b0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.sel, v.trans, 1'b0, v.size, v.addr, v.rdy, v.rv, v.rdata, v.rerr);
      tick();
      chk1({v.name, ".hreadyout"}, HREADYOUT, v.e_hrdy);
      chk1({v.name, ".hresp"}, HRESP, v.e_hresp);
      chk({v.name, ".hrdata"}, HRDATA, v.e_hrdata);
      chk1({v.name, ".req_valid"}, req_valid, v.e_reqv);
      if (v.e_reqv) chk({v.name, ".req_addr"}, req_addr, v.e_raddr);
    end

    // Write with a stalled host, then an error response.
    drive(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h2004, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk1("wr_wdata.hreadyout", HREADYOUT, 1'b0);
    chk1("wr_wdata.req_valid", req_valid, 1'b0);
    drive(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    HWDATA = 32'h12345678;
    tick();
    HWDATA = 32'hA5A5A5A5;
    chk1("wr_req.req_valid", req_valid, 1'b1);
    chk1("wr_req.req_write", req_write, 1'b1);
    chk("wr_req.req_addr", req_addr, 32'h2004);
    chk("wr_req.req_wdata", req_wdata, 32'h12345678);
    chk("wr_req.req_size", {29'd0, req_size}, 32'd2);
    chk1("wr_req.hreadyout", HREADYOUT, 1'b0);
    tick();
    chk1("wr_stall.req_valid", req_valid, 1'b1);
    chk("wr_stall.req_wdata", req_wdata, 32'h12345678);
    req_ready = 1'b1;
    tick();
    chk1("wr_wait.req_valid", req_valid, 1'b0);
    chk1("wr_wait.hreadyout", HREADYOUT, 1'b0);
    drive(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
    tick();
    resp_valid = 1'b0; resp_error = 1'b0;
    chk1("wr_err1.hreadyout", HREADYOUT, 1'b0);
    chk1("wr_err1.hresp", HRESP, 1'b1);
    chk("wr_err1.hrdata", HRDATA, 32'h0);
    tick();
    chk1("wr_err2.hreadyout", HREADYOUT, 1'b1);
    chk1("wr_err2.hresp", HRESP, 1'b1);
    tick();
    chk1("wr_idle.hresp", HRESP, 1'b0);

    // Host never takes the request: 8 stalled cycles, then withdrawal and ERROR.
    drive(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    low = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (HRESP) seen = 1'b1;
      else begin
        if (!HREADYOUT && req_valid) low++;
        tick();
      end
    end
    chk1("to.err_seen", seen, 1'b1);
    chk("to.stall_cycles", low, 32'd8);
    chk1("to_err1.hreadyout", HREADYOUT, 1'b0);
    chk1("to_err1.req_valid", req_valid, 1'b0);
    tick();
    chk1("to_err2.hreadyout", HREADYOUT, 1'b1);
    chk1("to_err2.hresp", HRESP, 1'b1);
    tick();
    drive(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b0);
    tick();
    resp_valid = 1'b0;
    chk("to_late.hrdata", HRDATA, 32'h0);
    chk1("to_late.hreadyout", HREADYOUT, 1'b1);
    chk1("to_late.hresp", HRESP, 1'b0);
    chk1("to_late.req_valid", req_valid, 1'b0);

    // Reset lands while a read waits on the host; the late response must not surface.
    drive(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h4000, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    resp_valid = 1'b1; resp_rdata = 32'hCAFEF00D;
    tick();
    chk("rst_pre.hrdata", HRDATA, 32'hCAFEF00D);
    drive(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h4004, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk1("rst_pre.req_valid", req_valid, 1'b1);
    drive(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk1("rst_wait.hreadyout", HREADYOUT, 1'b0);
    HRESETn = 1'b0;
    tick();
    chk_reset_outputs("rst_mid");
    HRESETn = 1'b1;
    resp_valid = 1'b1; resp_rdata = 32'h5A5A5A5A;
    tick();
    resp_valid = 1'b0;
    chk_reset_outputs("rst_late");
    tick();
    chk1("rst_after.hreadyout", HREADYOUT, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
